// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared types and helpers for the FIFO-fed UART transmitter
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DATA_W = 8;

  // Clock cycles from the first start-bit cycle to the end of the last stop bit.
  function automatic int frame_cycles(input int cpb, input int par, input int stop);
    return cpb * (1 + DATA_W + par + stop);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - clearable modulo-CLKS_PER_BIT counter producing bit boundary ticks
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int W = $clog2(CLKS_PER_BIT);

  logic [W-1:0] cnt;

  assign bit_tick = (cnt == W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from the FIFO and serialises them as UART frames
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] bytes_sent
);

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic [3:0]        bit_cnt;
  logic              stop_cnt;
  logic              parity;
  logic              bit_tick;
  logic              last_stop;
  logic              pop;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (pop),
    .bit_tick (bit_tick)
  );

  assign last_stop  = (state == STOP) && bit_tick && (stop_cnt == 1'(STOP_BITS - 1));
  // A pop in the last stop cycle chains straight into the next start bit.
  assign pop        = (state == IDLE || last_stop) && enable && !fifo_empty && rst;
  assign fifo_rd    = pop;
  assign frame_done = last_stop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      parity     <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      bytes_sent <= '0;
    end else begin
      if (last_stop) begin
        bytes_sent <= bytes_sent + 16'd1;
      end
      if (pop) begin
        state  <= START;
        shift  <= fifo_data;
        parity <= (^fifo_data) ^ 1'(PARITY_ODD);
        tx     <= 1'b0;
        busy   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
          START: begin
            if (bit_tick) begin
              state   <= DATA;
              bit_cnt <= '0;
              tx      <= shift[0];
            end
          end
          DATA: begin
            if (bit_tick) begin
              if (bit_cnt == 4'(DATA_W - 1)) begin
                stop_cnt <= 1'b0;
                if (PARITY_EN != 0) begin
                  state <= PARITY;
                  tx    <= parity;
                end else begin
                  state <= STOP;
                  tx    <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                shift   <= shift >> 1;
                tx      <= shift[1];
              end
            end
          end
          PARITY: begin
            if (bit_tick) begin
              state    <= STOP;
              stop_cnt <= 1'b0;
              tx       <= 1'b1;
            end
          end
          STOP: begin
            if (bit_tick) begin
              if (last_stop) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                stop_cnt <= stop_cnt + 1'b1;
              end
              tx <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - four parameter variants checked cycle by cycle against a frame-position model
module tb_fifo_uart_tx;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_empty_w [N];
  logic [7:0]  fifo_data_w  [N];
  logic        fifo_rd_w    [N];
  logic        tx_w         [N];
  logic        busy_w       [N];
  logic        done_w       [N];
  logic [15:0] bytes_w      [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    fifo_uart_tx #(
      .CLKS_PER_BIT (g == 3 ? 3 : 4),
      .PARITY_EN    ((g == 1 || g == 3) ? 1 : 0),
      .PARITY_ODD   (g == 3 ? 1 : 0),
      .STOP_BITS    (g >= 2 ? 2 : 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .fifo_empty (fifo_empty_w[g]),
      .fifo_data  (fifo_data_w[g]),
      .fifo_rd    (fifo_rd_w[g]),
      .tx         (tx_w[g]),
      .busy       (busy_w[g]),
      .frame_done (done_w[g]),
      .bytes_sent (bytes_w[g])
    );
  end

  int        cpb [N] = '{4, 4, 4, 3};
  int        par [N] = '{0, 1, 0, 1};
  int        odd [N] = '{0, 0, 0, 1};
  int        stp [N] = '{1, 1, 2, 2};
  int        flen [N];

  // Model: pos = cycles since the frame's first start-bit cycle, -1 when idle.
  logic [7:0]  fq [N][$];
  int          pos [N];
  logic [7:0]  cur [N];
  logic [15:0] cnt [N];
  bit          exp_pop [N];
  int          last_pop [N];
  int          interval [N];
  int          cyc;

  int   total = 0;
  int   bad   = 0;
  logic cap0 [10];
  logic par_cap [N];
  int   done_at0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_tx(input int i);
    int b;
    if (pos[i] < 0) return 1'b1;
    b = pos[i] / cpb[i];
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[i][b-1];
    if (b == 9 && par[i] != 0) return (^cur[i]) ^ 1'(odd[i]);
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    for (int i = 0; i < N; i++) if (fq[i].size() < 4) fq[i].push_back(b);
  endtask

  task automatic step();
    for (int i = 0; i < N; i++) begin
      fifo_empty_w[i] = (fq[i].size() == 0);
      fifo_data_w[i]  = (fq[i].size() == 0) ? 8'($urandom) : fq[i][0];
    end
    #1;
    for (int i = 0; i < N; i++) begin
      exp_pop[i] = (pos[i] < 0 || pos[i] == flen[i] - 1) && enable && fq[i].size() != 0 && rst;
      chk($sformatf("fifo_rd[%0d]", i), int'(fifo_rd_w[i]), int'(exp_pop[i]));
      chk($sformatf("tx[%0d]", i), int'(tx_w[i]), int'(exp_tx(i)));
      chk($sformatf("busy[%0d]", i), int'(busy_w[i]), int'(pos[i] >= 0));
      chk($sformatf("frame_done[%0d]", i), int'(done_w[i]), int'(pos[i] == flen[i] - 1));
      chk($sformatf("bytes_sent[%0d]", i), int'(bytes_w[i]), int'(cnt[i]));
      if (pos[i] == 9 * cpb[i] + 1) par_cap[i] = tx_w[i];
    end
    if (pos[0] >= 0 && pos[0] % 4 == 1 && pos[0] / 4 < 10) cap0[pos[0] / 4] = tx_w[0];
    if (done_w[0]) done_at0 = pos[0];
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        pos[i] = -1;
        cnt[i] = '0;
      end else begin
        if (pos[i] == flen[i] - 1) cnt[i] = cnt[i] + 16'd1;
        if (exp_pop[i]) begin
          cur[i] = fq[i].pop_front();
          pos[i] = 0;
          interval[i] = cyc - last_pop[i];
          last_pop[i] = cyc;
        end else if (pos[i] >= 0) begin
          pos[i] = (pos[i] + 1 == flen[i]) ? -1 : pos[i] + 1;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int n;
    cyc = 0;
    done_at0 = -1;
    for (int i = 0; i < N; i++) begin
      flen[i]     = cpb[i] * (9 + par[i] + stp[i]);
      pos[i]      = -1;
      cnt[i]      = '0;
      last_pop[i] = 0;
      interval[i] = 0;
      par_cap[i]  = 1'bx;
    end
    rst = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < N; i++) begin
      fifo_empty_w[i] = 1'b1;
      fifo_data_w[i]  = '0;
    end
    @(posedge clk);
    #1;
    run(3);
    for (int i = 0; i < N; i++) chk($sformatf("reset_bytes[%0d]", i), int'(bytes_w[i]), 0);
    rst = 1'b1;

    // Single byte 0xA5.
    enable = 1'b1;
    push(8'hA5);
    run(50);
    for (int k = 0; k < 10; k++)
      chk($sformatf("a5_bit%0d", k), int'(cap0[k]), int'((10'b11_0100_1010 >> k) & 1));
    chk("a5_done_pos", done_at0, 39);
    chk("a5_bytes_sent", int'(bytes_w[0]), 1);

    // Back-to-back 0x00, 0xFF: pop spacing equals the frame length.
    push(8'h00);
    push(8'hFF);
    run(100);
    chk("b2b_interval0", interval[0], 40);
    chk("b2b_interval1", interval[1], 44);
    chk("b2b_interval2", interval[2], 44);
    chk("b2b_interval3", interval[3], 36);
    chk("b2b_bytes_sent", int'(bytes_w[0]), 3);

    // Parity of 0x07: even sense -> 1, odd sense -> 0.
    push(8'h07);
    run(50);
    chk("parity_even", int'(par_cap[1]), 1);
    chk("parity_odd", int'(par_cap[3]), 0);

    // Empty FIFO, then enable dropped during the first of two queued frames.
    run(100);
    push(8'h3C);
    push(8'hC3);
    run(5);
    enable = 1'b0;
    run(60);
    chk("hold_queue_left", fq[0].size(), 1);
    chk("hold_bytes_sent", int'(bytes_w[0]), 5);

    // Reset pulse during data bit 3 of the next frame.
    enable = 1'b1;
    n = 0;
    while (pos[0] != 17 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("wait_data_bit3", n, 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("abort_tx", int'(tx_w[0]), 1);
    chk("abort_busy", int'(busy_w[0]), 0);
    chk("abort_bytes_sent", int'(bytes_w[0]), 0);
    push(8'h5A);
    run(50);
    chk("clean_bytes_sent", int'(bytes_w[0]), 1);

    // Randomised traffic with occasional enable drops and resets.
    for (int k = 0; k < 3000; k++) begin
      enable = ($urandom_range(0, 19) != 0);
      rst    = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 5) == 0) push(8'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
